// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory while holding the core stalled.
// Define IMEM_LOADER_CHECKSUM_EN to require a mod-256 checksum trailer byte after the image.
module imem_loader #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int WADDR_WIDTH   = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               byte_in,
   input  logic                     byte_valid,
   output logic                     byte_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_hold,
   output logic                     done,
   output logic                     err,
   output logic [WADDR_WIDTH:0]     words_loaded
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN0  = 3'd1;
   localparam logic [2:0] S_LEN1  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_CHK   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;
   localparam logic [2:0] S_ERR   = 3'd7;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_FINAL = S_CHK;
`else
   localparam logic [2:0] S_FINAL = S_DONE;
`endif

   localparam int unsigned CAPACITY = 32'd1 << WADDR_WIDTH;

   logic [2:0]           state;
   logic [15:0]          len_q;
   logic [1:0]           byte_idx;
   logic [23:0]          shift_q;
   logic [WADDR_WIDTH:0] word_cnt;
   logic [15:0]          len_next;
   logic                 xfer;
   logic                 last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]           csum;
`endif

   assign xfer      = byte_valid && byte_ready;
   assign len_next  = {byte_in, len_q[7:0]};
   assign last_word = (32'(word_cnt) + 32'd1) == 32'(len_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         len_q     <= '0;
         byte_idx  <= '0;
         shift_q   <= '0;
         word_cnt  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            S_IDLE, S_ERR: begin
               if (start) begin
                  state    <= S_LEN0;
                  word_cnt <= '0;
                  byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            S_LEN0: begin
               if (xfer) begin
                  len_q[7:0] <= byte_in;
                  state      <= S_LEN1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum       <= csum + byte_in;
`endif
               end
            end
            S_LEN1: begin
               if (xfer) begin
                  len_q[15:8] <= byte_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum        <= csum + byte_in;
`endif
                  // An oversized image is rejected before anything touches memory
                  if (32'(len_next) > CAPACITY)
                     state <= S_ERR;
                  else if (len_next == 16'd0)
                     state <= S_FINAL;
                  else
                     state <= S_DATA;
               end
            end
            S_DATA: begin
               if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= csum + byte_in;
`endif
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: shift_q[7:0]   <= byte_in;
                     2'd1: shift_q[15:8]  <= byte_in;
                     2'd2: shift_q[23:16] <= byte_in;
                     default: begin
                        mem_wdata <= DATA_WIDTH'({byte_in, shift_q});
                        mem_addr  <= ADDRESS_WIDTH'({word_cnt, 2'b00});
                        state     <= S_WRITE;
                     end
                  endcase
               end
            end
            S_WRITE: begin
               word_cnt <= word_cnt + 1'b1;
               byte_idx <= '0;
               state    <= last_word ? S_FINAL : S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (xfer)
                  state <= (byte_in == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign byte_ready   = (state == S_LEN0) || (state == S_LEN1) ||
                         (state == S_DATA) || (state == S_CHK);
   assign mem_we       = (state == S_WRITE);
   assign done         = (state == S_DONE);
   assign err          = (state == S_ERR);
   assign cpu_hold     = (state != S_IDLE) && (state != S_DONE);
   assign words_loaded = word_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes/done events, a negedge monitor checks them.
module tb_imem_loader;

   localparam int AW  = 32;
   localparam int WW  = 4;
   localparam int CAP = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          err;
   logic [WW:0]   words_loaded;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [63:0] exp_wr_q[$];
   int          exp_done_q[$];
   logic [7:0]  stim_q[$];
   logic [31:0] img[0:31];

   imem_loader #(.DATA_WIDTH(32), .ADDRESS_WIDTH(AW), .WADDR_WIDTH(WW)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Monitor pops the scoreboard whenever the DUT writes or signals completion
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            checkOutput("write_ready_low", 32'(byte_ready), 32'd0);
            if (exp_wr_q.size() == 0) begin
               total_cnt++;
               $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
               logic [63:0] e;
               e = exp_wr_q.pop_front();
               checkOutput("write_addr", mem_addr, e[63:32]);
               checkOutput("write_data", mem_wdata, e[31:0]);
            end
         end
         if (done) begin
            checkOutput("done_cpu_hold", 32'(cpu_hold), 32'd0);
            if (exp_done_q.size() == 0) begin
               total_cnt++;
               $display("[TB] FAIL unexpected_done: got done=1, expected 0");
            end else begin
               int n;
               n = exp_done_q.pop_front();
               checkOutput("done_words", 32'(words_loaded), 32'(n));
            end
         end
      end
   end

   task automatic buildLoad(input int n, input bit bad_trailer);
      logic [7:0] sum;
      logic [7:0] b;
      stim_q.delete();
      b = n[7:0];  stim_q.push_back(b); sum = b;
      b = n[15:8]; stim_q.push_back(b); sum = sum + b;
      if (n <= CAP) begin
         for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
               b = img[i][8*k +: 8];
               stim_q.push_back(b);
               sum = sum + b;
            end
            exp_wr_q.push_back({32'(i * 4), img[i]});
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         stim_q.push_back(bad_trailer ? sum + 8'd1 : sum);
`endif
         if (!bad_trailer) exp_done_q.push_back(n);
      end
   endtask

   task automatic applyStimulus(input bit gaps);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      foreach (stim_q[i]) begin
         bit accepted;
         int tries;
         accepted = 1'b0;
         tries    = 0;
         while (!accepted && tries < 200) begin
            if (gaps && $urandom_range(0, 1) == 0) begin
               byte_valid = 1'b0;
               byte_in    = 8'($urandom);
            end else begin
               byte_valid = 1'b1;
               byte_in    = stim_q[i];
            end
            accepted = byte_valid && byte_ready;
            @(negedge clk);
            tries++;
         end
         if (!accepted) begin
            total_cnt++;
            $display("[TB] FAIL byte_timeout: byte %0d not accepted, expected acceptance", i);
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic waitSettled();
      int t = 0;
      while (cpu_hold && !err && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         total_cnt++;
         $display("[TB] FAIL settle_timeout: cpu_hold=%0b err=%0b, expected completion", cpu_hold, err);
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      repeat (3) @(negedge clk);
      checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
      checkOutput("rst_ready", 32'(byte_ready), 32'd0);
      checkOutput("rst_words", 32'(words_loaded), 32'd0);
      checkOutput("rst_addr", mem_addr, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] N=2 back-to-back load");
      img[0] = 32'h0010_0513; img[1] = 32'h00A5_85B3;
      buildLoad(2, 1'b0); applyStimulus(1'b0); waitSettled();
      checkOutput("n2_words", 32'(words_loaded), 32'd2);
      checkOutput("n2_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("n2_err", 32'(err), 32'd0);

      $display("[TB] N=2 load with random valid gaps");
      buildLoad(2, 1'b0); applyStimulus(1'b1); waitSettled();
      checkOutput("gap_words", 32'(words_loaded), 32'd2);
      checkOutput("gap_cpu_hold", 32'(cpu_hold), 32'd0);

      $display("[TB] N=0 load");
      buildLoad(0, 1'b0); applyStimulus(1'b0); waitSettled();
      checkOutput("n0_words", 32'(words_loaded), 32'd0);
      checkOutput("n0_cpu_hold", 32'(cpu_hold), 32'd0);

      $display("[TB] N=17 exceeds capacity");
      buildLoad(17, 1'b0); applyStimulus(1'b0); waitSettled();
      repeat (3) @(negedge clk);
      checkOutput("ovf_err", 32'(err), 32'd1);
      checkOutput("ovf_cpu_hold", 32'(cpu_hold), 32'd1);
      checkOutput("ovf_ready", 32'(byte_ready), 32'd0);

      $display("[TB] N=1 load clears error");
      img[0] = 32'h1234_5678;
      buildLoad(1, 1'b0); applyStimulus(1'b0); waitSettled();
      checkOutput("rec_err", 32'(err), 32'd0);
      checkOutput("rec_words", 32'(words_loaded), 32'd1);

      $display("[TB] N=16 fills capacity");
      for (int i = 0; i < 16; i++) img[i] = 32'hA500_0000 + 32'(i * 32'h0001_0203);
      buildLoad(16, 1'b0); applyStimulus(1'b0); waitSettled();
      checkOutput("full_words", 32'(words_loaded), 32'd16);
      checkOutput("full_err", 32'(err), 32'd0);

      $display("[TB] reset during N=3 load");
      img[0] = 32'hDEAD_BEEF;
      stim_q.delete();
      stim_q.push_back(8'h03); stim_q.push_back(8'h00);
      stim_q.push_back(8'hEF); stim_q.push_back(8'hBE);
      stim_q.push_back(8'hAD); stim_q.push_back(8'hDE);
      exp_wr_q.push_back({32'h0, 32'hDEAD_BEEF});
      applyStimulus(1'b0);
      checkOutput("mid_first_we", 32'(mem_we), 32'd1);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("mid_rst_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("mid_rst_addr", mem_addr, 32'd0);
      checkOutput("mid_rst_data", mem_wdata, 32'd0);
      checkOutput("mid_rst_words", 32'(words_loaded), 32'd0);
      checkOutput("mid_rst_ready", 32'(byte_ready), 32'd0);
      @(negedge clk); rst = 1'b0;
      img[0] = 32'h0000_0093; img[1] = 32'h0010_8093;
      buildLoad(2, 1'b0); applyStimulus(1'b0); waitSettled();
      checkOutput("post_rst_words", 32'(words_loaded), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
      $display("[TB] checksum trailer good and bad");
      img[0] = 32'h0000_0013;
      buildLoad(1, 1'b0); applyStimulus(1'b0); waitSettled();
      checkOutput("chk_good_err", 32'(err), 32'd0);
      checkOutput("chk_good_words", 32'(words_loaded), 32'd1);
      buildLoad(1, 1'b1); applyStimulus(1'b0); waitSettled();
      checkOutput("chk_bad_err", 32'(err), 32'd1);
      checkOutput("chk_bad_cpu_hold", 32'(cpu_hold), 32'd1);
`endif

      repeat (3) @(negedge clk);
      checkOutput("writes_pending", 32'(exp_wr_q.size()), 32'd0);
      checkOutput("done_pending", 32'(exp_done_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
